// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the two-requester UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_BUSY_WAIT_MAX  = 16;
  localparam logic [7:0] HDR_BASE   = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    DONE
  } arb_state_e;

  function automatic logic [7:0] hdr_byte(input logic id);
    return HDR_BASE | {7'd0, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and byte-transmitter signals seen by the arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if #(
  parameter int BYTES_PER_WORD = uart_arb_pkg::DEF_BYTES_PER_WORD
);
  localparam int WORD_W = 8 * BYTES_PER_WORD;

  logic [1:0]        req;
  logic [WORD_W-1:0] word0;
  logic [WORD_W-1:0] word1;
  logic [1:0]        ack;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              active;
  logic              grant_id;

  modport slave (
    input  req, word0, word1, tx_busy,
    output ack, tx_data, tx_start, active, grant_id
  );

  modport master (
    output req, word0, word1, tx_busy,
    input  ack, tx_data, tx_start, active, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o
);
  always_comb begin
    sel_o = last_i;
    if (&req_i) begin
      sel_o = ~last_i;
    end else if (req_i[0]) begin
      sel_o = 1'b0;
    end else if (req_i[1]) begin
      sel_o = 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Serializes requester words MSB-first onto a shared byte UART transmitter, one locked frame per grant.
// Optional header byte (HDR_BASE | grant_id) ahead of each word when UART_FRAME_HDR_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int BUSY_WAIT_MAX  = DEF_BUSY_WAIT_MAX
) (
  input  logic              clock_i,
  input  logic              reset_i,
  uart_tx_arbiter_if.slave  bus_if
);
`ifdef UART_FRAME_HDR_EN
  localparam int FRAME_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int FRAME_BYTES = BYTES_PER_WORD;
`endif
  localparam int SHIFT_W = 8 * FRAME_BYTES;
  localparam int CNT_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int WAIT_W  = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               grant_q, grant_d;
  logic               sel;
  logic [SHIFT_W-1:0] load_word;

  rr_arb2 u_rr_arb2 (
    .req_i  (bus_if.req),
    .last_i (grant_q),
    .sel_o  (sel)
  );

`ifdef UART_FRAME_HDR_EN
  assign load_word = {hdr_byte(sel), (sel ? bus_if.word1 : bus_if.word0)};
`else
  assign load_word = sel ? bus_if.word1 : bus_if.word0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if ((|bus_if.req) && !bus_if.tx_busy) begin
          grant_d = sel;
          shift_d = load_word;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        // A start the transmitter never acknowledged is treated as lost and resent.
        if (bus_if.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus_if.tx_busy) begin
          if (cnt_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      grant_q <= grant_d;
    end
  end

  assign bus_if.tx_start = (state_q == ISSUE);
  assign bus_if.tx_data  = (state_q == ISSUE) ? shift_q[SHIFT_W-1 -: 8] : 8'h00;
  assign bus_if.active   = (state_q != IDLE);
  assign bus_if.grant_id = grant_q;
  assign bus_if.ack      = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded random bench: expected frames are queued at request time, a negedge monitor checks them at ack.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int BPW = DEF_BYTES_PER_WORD;
  localparam int BWM = DEF_BUSY_WAIT_MAX;
`ifdef UART_FRAME_HDR_EN
  localparam int FRAME_BYTES = BPW + 1;
  localparam bit HDR = 1'b1;
`else
  localparam int FRAME_BYTES = BPW;
  localparam bit HDR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.BYTES_PER_WORD(BPW)) bus_if ();

  uart_tx_arbiter #(
    .BYTES_PER_WORD (BPW),
    .BUSY_WAIT_MAX  (BWM)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus_if  (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  bit          last_grant = 1'b1;
  int          exp_id_q[$];
  logic [31:0] exp_word_q[$];
  logic [7:0]  got_q[$];

  // transmitter model knobs and state
  bit   busy_m = 1'b0;
  int   busy_dly = 3;
  int   busy_len = 20;
  int   ignore_req = 0;
  int   ignore_done = 0;
  int   flush_req = 0;
  int   flush_done = 0;
  bit   pending = 1'b0;
  int   pend_cnt = 0;
  int   rem = 0;
  bit   reissue_due = 1'b0;
  logic [7:0] ignored_byte = 8'h00;
  int   ignored_cyc = 0;
  logic [1:0] prev_ack = 2'b00;
  bit   mon_accept = 1'b0;

  assign bus_if.tx_busy = busy_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input bit id, input logic [31:0] w, input int k);
    logic [31:0] t;
    int j;
    j = k;
    if (HDR) begin
      if (k == 0) return 8'hA0 | {7'd0, id};
      j = k - 1;
    end
    t = w >> (8 * (BPW - 1 - j));
    return t[7:0];
  endfunction

  task automatic push_frame(input bit id, input logic [31:0] w);
    exp_id_q.push_back(id);
    exp_word_q.push_back(w);
    last_grant = id;
  endtask

  // monitor + transmitter model
  always @(negedge clk) begin
    mon_accept = 1'b0;
    if (flush_req != flush_done) begin
      got_q.delete();
      flush_done = flush_req;
    end
    if (rst) begin
      prev_ack = 2'b00;
    end else begin
      if (prev_ack != 2'b00) check("ack_single_pulse", {30'd0, bus_if.ack}, 32'd0);
      prev_ack = bus_if.ack;
      if (bus_if.tx_start) begin
        check("active_at_start", {31'd0, bus_if.active}, 32'd1);
        if (ignore_req != ignore_done) begin
          ignore_done++;
          ignored_byte = bus_if.tx_data;
          ignored_cyc = cyc;
          reissue_due = 1'b1;
        end else begin
          mon_accept = 1'b1;
          got_q.push_back(bus_if.tx_data);
          if (reissue_due) begin
            reissue_due = 1'b0;
            check("reissue_byte", {24'd0, bus_if.tx_data}, {24'd0, ignored_byte});
            check("reissue_gap_in_range",
                  {31'd0, ((cyc - ignored_cyc) >= BWM) && ((cyc - ignored_cyc) <= BWM + 2)}, 32'd1);
          end
        end
      end
      if (bus_if.ack != 2'b00) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: ack=%b with no frame outstanding (cycle %0d)", bus_if.ack, cyc);
        end else begin
          int id;
          logic [31:0] w;
          id = exp_id_q.pop_front();
          w = exp_word_q.pop_front();
          check("ack_index", {30'd0, bus_if.ack}, (id != 0) ? 32'd2 : 32'd1);
          check("active_in_ack", {31'd0, bus_if.active}, 32'd1);
          check("frame_len", got_q.size(), FRAME_BYTES);
          for (int k = 0; k < FRAME_BYTES; k++) begin
            check($sformatf("frame_byte%0d", k),
                  {24'd0, (k < got_q.size()) ? got_q[k] : 8'h00},
                  {24'd0, exp_byte(id != 0, w, k)});
          end
          $display("frame id=%0d word=%08h bytes=%0d cycle=%0d", id, w, got_q.size(), cyc);
        end
        got_q.delete();
      end
    end
    if (mon_accept) begin
      pending = 1'b1;
      pend_cnt = busy_dly;
    end else if (pending) begin
      if (pend_cnt <= 1) begin
        busy_m = 1'b1;
        pending = 1'b0;
        rem = busy_len;
      end else begin
        pend_cnt--;
      end
    end else if (busy_m) begin
      if (rem <= 1) busy_m = 1'b0;
      else rem--;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = !bus_if.active && !busy_m && !pending;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: arbiter or transmitter still busy (cycle %0d)", cyc);
    end
  endtask

  task automatic serve(input logic [1:0] pat, input bit mutate);
    bit order[2];
    int nf;
    int k;
    bit mutated;
    bit saw_start;
    bit done;
    int req_cyc;
    nf = (pat == 2'b11) ? 2 : 1;
    order[0] = (pat == 2'b11) ? !last_grant : (pat == 2'b10);
    order[1] = !order[0];
    for (int i = 0; i < nf; i++) push_frame(order[i], order[i] ? bus_if.word1 : bus_if.word0);
    bus_if.req = pat;
    req_cyc = cyc;
    k = 0;
    mutated = 1'b0;
    saw_start = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 600 * nf && !done; c++) begin
      @(negedge clk);
      if (bus_if.tx_start && !saw_start) begin
        saw_start = 1'b1;
        check("req_to_start_latency", cyc - req_cyc, 32'd1);
      end
      if (bus_if.tx_start && mutate && !mutated) begin
        mutated = 1'b1;
        if (order[k]) bus_if.word1 = $urandom;
        else bus_if.word0 = $urandom;
        if ($urandom_range(0, 1) == 1) bus_if.req[order[k]] = 1'b0;
      end
      if (bus_if.ack != 2'b00) begin
        bus_if.req[order[k]] = 1'b0;
        k++;
        mutated = 1'b0;
        if (k == nf) done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: %0d of %0d acks seen", k, nf);
      bus_if.req = 2'b00;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    logic [1:0] pat;
    bus_if.req = 2'b00;
    bus_if.word0 = '0;
    bus_if.word1 = '0;

    // reset, then idle outputs
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_tx_start", {31'd0, bus_if.tx_start}, 32'd0);
      check("rst_ack", {30'd0, bus_if.ack}, 32'd0);
      check("rst_active", {31'd0, bus_if.active}, 32'd0);
      check("rst_grant_id", {31'd0, bus_if.grant_id}, 32'd1);
    end

    // single requester 0
    bus_if.word0 = 32'hDEADBEEF;
    busy_dly = 3;
    busy_len = 20;
    serve(2'b01, 1'b0);
    wait_idle();

    // both held continuously: four alternating frames
    bus_if.word0 = 32'h11111111;
    bus_if.word1 = 32'h22222222;
    busy_len = 6;
    for (int i = 0; i < 4; i++) push_frame(!last_grant, (!last_grant) ? bus_if.word1 : bus_if.word0);
    bus_if.req = 2'b11;
    k = 0;
    for (int c = 0; c < 2000 && k < 4; c++) begin
      @(negedge clk);
      if (bus_if.ack != 2'b00) k++;
    end
    bus_if.req = 2'b00;
    check("held_req_acks", k, 32'd4);
    wait_idle();

    // lost start byte must be resent
    bus_if.word0 = 32'hCAFE0123;
    ignore_req++;
    serve(2'b01, 1'b0);
    wait_idle();

    // reset during the third byte aborts the frame without ack
    bus_if.word0 = 32'h55AA33CC;
    busy_dly = 2;
    busy_len = 10;
    bus_if.req = 2'b01;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = (got_q.size() >= 3);
    end
    check("abort_third_byte_reached", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_if.req = 2'b00;
    flush_req++;
    @(negedge clk);
    check("abort_active", {31'd0, bus_if.active}, 32'd0);
    check("abort_tx_start", {31'd0, bus_if.tx_start}, 32'd0);
    check("abort_ack", {30'd0, bus_if.ack}, 32'd0);
    check("abort_grant_id", {31'd0, bus_if.grant_id}, 32'd1);
    rst = 1'b0;
    last_grant = 1'b1;
    repeat (40) @(negedge clk);
    wait_idle();
    bus_if.word1 = 32'h8899AABB;
    serve(2'b10, 1'b0);
    wait_idle();

    // requester 1 word (carries the header byte when that feature is built in)
    bus_if.word1 = 32'h01020304;
    serve(2'b10, 1'b0);
    wait_idle();

    // randomized traffic with mid-frame payload changes and early req drops
    for (int it = 0; it < 16; it++) begin
      bus_if.word0 = $urandom;
      bus_if.word1 = $urandom;
      busy_dly = $urandom_range(1, 5);
      busy_len = $urandom_range(2, 12);
      case ($urandom_range(0, 2))
        0:       pat = 2'b01;
        1:       pat = 2'b10;
        default: pat = 2'b11;
      endcase
      if ($urandom_range(0, 3) == 0) ignore_req++;
      serve(pat, 1'b1);
      wait_idle();
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_id_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
